// File: rtl/clock_set_ctrl_if.sv
// rtl/clock_set_ctrl_if.sv - tick/button inputs and time/edit display outputs of clock_set_ctrl
interface clock_set_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [1:0] edit_sel;
  logic       blink;

  modport master (
    output tick_1hz, btn_mode, btn_inc,
    input  hour, min, sec, edit_sel, blink
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc,
    output hour, min, sec, edit_sel, blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - run/set timekeeping controller for the clock display path
module clock_set_ctrl #(
  parameter bit H24       = 1'b1,
  parameter int TIMEOUT_S = 10
) (
  input  logic             clk_50Mhz,
  input  logic             rst_n,
  clock_set_ctrl_if.slave  cs
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  localparam logic [4:0] HOUR_RST = H24 ? 5'd0 : 5'd12;
  localparam logic [5:0] TO_LIM   = 6'(TIMEOUT_S);

  state_t     state;
  logic [4:0] hour_q;
  logic [5:0] min_q;
  logic [5:0] sec_q;
  logic       blink_q;
  logic [5:0] to_cnt;
  logic       btn_mode_q;
  logic       btn_inc_q;
  logic       mode_evt;
  logic       inc_evt;

  // Minutes and seconds share the same 0..59 wrap.
  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  // Hour wraps 23->0 in 24-hour mode, 12->1 in 12-hour mode.
  function automatic logic [4:0] inc_hour(input logic [4:0] v);
    if (H24) return (v == 5'd23) ? 5'd0 : v + 5'd1;
    else     return (v == 5'd12) ? 5'd1 : v + 5'd1;
  endfunction

  assign mode_evt = cs.btn_mode & ~btn_mode_q;
  assign inc_evt  = cs.btn_inc  & ~btn_inc_q;

  // Button history; reset high so a button held through reset gives no edge.
  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      btn_mode_q <= 1'b1;
      btn_inc_q  <= 1'b1;
    end else begin
      btn_mode_q <= cs.btn_mode;
      btn_inc_q  <= cs.btn_inc;
    end
  end

  // Run/set FSM with time counters, edit timeout and blink.
  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      hour_q  <= HOUR_RST;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      blink_q <= 1'b0;
      to_cnt  <= 6'd0;
    end else begin
      case (state)
        RUN: begin
          blink_q <= 1'b0;
          to_cnt  <= 6'd0;
          if (cs.tick_1hz) begin
            sec_q <= inc60(sec_q);
            if (sec_q == 6'd59) begin
              min_q <= inc60(min_q);
              if (min_q == 6'd59) hour_q <= inc_hour(hour_q);
            end
          end
          if (mode_evt) state <= SET_H;
        end
        default: begin
          // Expiry outranks a simultaneous mode press; the mode press outranks inc.
          if (to_cnt == TO_LIM) begin
            state   <= RUN;
            to_cnt  <= 6'd0;
            blink_q <= 1'b0;
          end else if (mode_evt) begin
            to_cnt <= 6'd0;
            case (state)
              SET_H:   state <= SET_M;
              SET_M:   state <= SET_S;
              default: begin
                state   <= RUN;
                blink_q <= 1'b0;
              end
            endcase
          end else if (inc_evt) begin
            to_cnt  <= 6'd0;
            blink_q <= 1'b1;
            case (state)
              SET_H:   hour_q <= inc_hour(hour_q);
              SET_M:   min_q  <= inc60(min_q);
              default: sec_q  <= 6'd0;
            endcase
          end else if (cs.tick_1hz) begin
            blink_q <= ~blink_q;
            to_cnt  <= to_cnt + 6'd1;
          end
        end
      endcase
    end
  end

  assign cs.hour     = hour_q;
  assign cs.min      = min_q;
  assign cs.sec      = sec_q;
  assign cs.edit_sel = state;
  assign cs.blink    = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - self-checking bench for clock_set_ctrl in 24h and 12h builds
`timescale 1ns/1ps
module tb_clock_set_ctrl;

  localparam int TO_S = 10;
  localparam int A_MODE = 0, A_INC = 1, A_TICK = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic tick, bm, bi;
  logic tick_prev;

  clock_set_ctrl_if if24 ();
  clock_set_ctrl_if if12 ();

  assign if24.tick_1hz = tick;
  assign if24.btn_mode = bm;
  assign if24.btn_inc  = bi;
  assign if12.tick_1hz = tick;
  assign if12.btn_mode = bm;
  assign if12.btn_inc  = bi;

  clock_set_ctrl #(.H24(1'b1), .TIMEOUT_S(TO_S)) dut24 (
    .clk_50Mhz(clk), .rst_n(rst_n), .cs(if24)
  );
  clock_set_ctrl #(.H24(1'b0), .TIMEOUT_S(TO_S)) dut12 (
    .clk_50Mhz(clk), .rst_n(rst_n), .cs(if12)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: hour kept as an index into an N-hour day (index 0 shows
  // as 12 in 12-hour mode), running time advanced as a seconds-of-day total.
  int m_mode, m_to, m_blink, m_min, m_sec;
  int m_hidx [2];
  bit m_bq, m_iq;

  function automatic int nh(input int k);
    return (k == 0) ? 24 : 12;
  endfunction

  function automatic int disp_hour(input int k);
    return (k == 1 && m_hidx[1] == 0) ? 12 : m_hidx[k];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_to = 0; m_blink = 0; m_min = 0; m_sec = 0;
    m_hidx[0] = 0; m_hidx[1] = 0;
    m_bq = 1'b1; m_iq = 1'b1;
  endtask

  task automatic model_step();
    bit me, ie;
    int tot;
    me = bm && !m_bq;
    ie = bi && !m_iq;
    m_bq = bm;
    m_iq = bi;
    if (m_mode == 0) begin
      if (tick) begin
        for (int k = 0; k < 2; k++) begin
          tot = (m_hidx[k] * 3600 + m_min * 60 + m_sec + 1) % (nh(k) * 3600);
          m_hidx[k] = tot / 3600;
        end
        tot = (m_min * 60 + m_sec + 1) % 3600;
        m_min = tot / 60;
        m_sec = tot % 60;
      end
      if (me) m_mode = 1;
      m_blink = 0;
      m_to = 0;
    end else if (m_to == TO_S) begin
      m_mode = 0; m_blink = 0; m_to = 0;
    end else if (me) begin
      m_mode = (m_mode + 1) % 4;
      m_to = 0;
      if (m_mode == 0) m_blink = 0;
    end else if (ie) begin
      if (m_mode == 1) for (int k = 0; k < 2; k++) m_hidx[k] = (m_hidx[k] + 1) % nh(k);
      else if (m_mode == 2) m_min = (m_min + 1) % 60;
      else m_sec = 0;
      m_blink = 1;
      m_to = 0;
    end else if (tick) begin
      m_blink = 1 - m_blink;
      m_to++;
    end
  endtask

  // One clock: advance the model, let the DUT clock, then compare away from the edge.
  task automatic cyc();
    if (!rst_n) model_reset();
    else model_step();
    chk("tick_single", int'(tick && tick_prev), 0);
    tick_prev = tick;
    @(posedge clk);
    #1;
    chk("m24_edit", if24.edit_sel, m_mode);
    chk("m24_hour", if24.hour, disp_hour(0));
    chk("m24_min", if24.min, m_min);
    chk("m24_sec", if24.sec, m_sec);
    chk("m24_blink", if24.blink, m_blink);
    chk("m12_edit", if12.edit_sel, m_mode);
    chk("m12_hour", if12.hour, disp_hour(1));
    chk("m12_min", if12.min, m_min);
    chk("m12_sec", if12.sec, m_sec);
    chk("m12_blink", if12.blink, m_blink);
    chk("range24", int'(if24.hour < 24 && if24.min < 60 && if24.sec < 60), 1);
    chk("range12", int'(if12.hour >= 1 && if12.hour <= 12 && if12.min < 60 && if12.sec < 60), 1);
  endtask

  task automatic press_mode();
    bm = 1'b1; cyc(); bm = 1'b0; cyc();
  endtask

  task automatic press_inc();
    bi = 1'b1; cyc(); bi = 1'b0; cyc();
  endtask

  task automatic do_tick();
    tick = 1'b1; cyc(); tick = 1'b0; cyc();
  endtask

  task automatic do_action(input int act, input int n);
    for (int i = 0; i < n; i++) begin
      if (act == A_MODE) press_mode();
      else if (act == A_INC) press_inc();
      else do_tick();
    end
  endtask

  task automatic chk_time(input string name, input int e_edit, input int h24, input int h12,
                          input int mn, input int sc);
    chk({name, "_edit"}, if24.edit_sel, e_edit);
    chk({name, "_h24"}, if24.hour, h24);
    chk({name, "_h12"}, if12.hour, h12);
    chk({name, "_min"}, if24.min, mn);
    chk({name, "_sec"}, if24.sec, sc);
  endtask

  typedef struct {
    int act; int n; int edit; int h24; int h12; int mn; int sc; int bl;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{A_MODE, 1,  1, 5'd0, 12, 0,  0, -1};
    tbl[1] = '{A_INC,  5,  1, 5,    5,  0,  0,  1};
    tbl[2] = '{A_MODE, 1,  2, 5,    5,  0,  0, -1};
    tbl[3] = '{A_INC,  30, 2, 5,    5,  30, 0,  1};
    tbl[4] = '{A_MODE, 1,  3, 5,    5,  30, 0, -1};
    tbl[5] = '{A_INC,  1,  3, 5,    5,  30, 0,  1};
    tbl[6] = '{A_MODE, 1,  0, 5,    5,  30, 0,  0};
    tbl[7] = '{A_TICK, 1,  0, 5,    5,  30, 1,  0};

    rst_n = 1'b0; tick = 1'b0; bm = 1'b0; bi = 1'b0; tick_prev = 1'b0;
    model_reset();
    cyc(); cyc();
    chk_time("reset", 0, 0, 12, 0, 0);
    chk("reset_blink", if24.blink, 0);
    rst_n = 1'b1;
    cyc();

    // Set cycle, table driven
    foreach (tbl[i]) begin
      do_action(tbl[i].act, tbl[i].n);
      chk_time($sformatf("tbl%0d", i), tbl[i].edit, tbl[i].h24, tbl[i].h12, tbl[i].mn, tbl[i].sc);
      if (tbl[i].bl >= 0) chk($sformatf("tbl%0d_blink", i), if24.blink, tbl[i].bl);
    end

    // Freeze and blink in SET_M
    do_action(A_MODE, 2);
    chk("frz_edit", if24.edit_sel, 2);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      chk($sformatf("frz_blink%0d", i), if24.blink, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("frz_sec%0d", i), if24.sec, 1);
    end
    bi = 1'b1; cyc();
    chk("inc_blink", if24.blink, 1);
    chk("inc_min", if24.min, 31);
    bi = 1'b0; cyc();
    do_action(A_MODE, 2);
    chk("run_blink", if24.blink, 0);
    chk_time("frz_end", 0, 5, 5, 31, 1);

    // Carry chain: preset 23:59:58, two ticks
    do_action(A_MODE, 1); do_action(A_INC, 18);
    do_action(A_MODE, 1); do_action(A_INC, 28);
    do_action(A_MODE, 1); do_action(A_INC, 1);
    do_action(A_MODE, 1);
    do_action(A_TICK, 58);
    chk_time("cc_58", 0, 23, 11, 59, 58);
    do_tick();
    chk_time("cc_59", 0, 23, 11, 59, 59);
    tick = 1'b1; cyc();
    chk_time("cc_wrap", 0, 0, 12, 0, 0);
    tick = 1'b0; cyc();

    // 12-hour rollover 12:59:59 -> 01:00:00 and set-mode 12 -> 1
    do_action(A_MODE, 2); do_action(A_INC, 59);
    do_action(A_MODE, 1); do_action(A_INC, 1);
    do_action(A_MODE, 1);
    do_action(A_TICK, 59);
    chk_time("h12_pre", 0, 0, 12, 59, 59);
    do_tick();
    chk_time("h12_roll", 0, 1, 1, 0, 0);
    do_action(A_MODE, 1); do_action(A_INC, 11);
    chk_time("h12_at12", 1, 12, 12, 0, 0);
    do_action(A_INC, 1);
    chk_time("h12_wrap", 1, 13, 1, 0, 0);
    do_action(A_MODE, 3);

    // Edit timeout
    do_action(A_MODE, 1);
    do_action(A_TICK, 9);
    chk("to_9", if24.edit_sel, 1);
    do_action(A_INC, 1);
    do_action(A_TICK, 9);
    chk("to_inc9", if24.edit_sel, 1);
    do_tick();
    chk("to_exp", if24.edit_sel, 0);
    chk("to_hour", if24.hour, 14);

    // Simultaneous mode+inc in SET_H with hour 7
    do_action(A_MODE, 1); do_action(A_INC, 17);
    chk("sim_pre", if24.hour, 7);
    bm = 1'b1; bi = 1'b1; cyc();
    chk_time("sim", 2, 7, 7, 0, 0);
    bm = 1'b0; bi = 1'b0; cyc();
    do_action(A_MODE, 2);

    // Reset mid-operation with btn_mode held through release
    do_action(A_MODE, 1);
    bm = 1'b1; cyc();
    rst_n = 1'b0; cyc(); cyc();
    chk_time("rst_mid", 0, 0, 12, 0, 0);
    rst_n = 1'b1; cyc(); cyc(); cyc();
    chk("hold_edit", if24.edit_sel, 0);
    bm = 1'b0; cyc();
    chk("hold_rel", if24.edit_sel, 0);
    bm = 1'b1; cyc();
    chk("hold_press", if24.edit_sel, 1);
    bm = 1'b0; cyc();

    // Randomized stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      tick = (!tick && $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) bm = ~bm;
      if ($urandom_range(0, 3) == 0) bi = ~bi;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Timekeeping and time-setting controller for the clock display path.
- Consumes the single-cycle 1 Hz enable from the 1 Hz generator and two debounced, synchronised push-buttons.
- Sequences the hours/minutes/seconds counters through a run/set state machine.
- Drives the BCD/7-segment display stage with the current time, the field being edited and a blink enable.

Parameters:
- H24, 1: 1 selects a 0..23 hour range; 0 selects 1..12.
- TIMEOUT_S, 10: number of tick_1hz pulses with no button edge in any SET state before the block returns to RUN. Legal range 1..63.

Ports:
- clk_50Mhz  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- tick_1hz  input  1  one-clk_50Mhz-cycle pulse, once per second.
- btn_mode  input  1  mode button level, debounced, synchronous, active-high.
- btn_inc  input  1  increment button level, debounced, synchronous, active-high.
- hour  output  5  current hour.
- min  output  6  current minute, 0..59.
- sec  output  6  current second, 0..59.
- edit_sel  output  2  0=RUN, 1=hour, 2=min, 3=sec field under edit.
- blink  output  1  display blanking enable for the edited field.

Behaviour:
- Reset (async, rst_n=0):
  - hour=0 if H24=1, else 12.
  - min=0, sec=0, edit_sel=0, blink=0.
  - Timeout counter = 0.
  - Button history registers reset to 1, so a button held through reset release produces no edge.
- Edge detect:
  - mode_evt = btn_mode & ~btn_mode_q; inc_evt = btn_inc & ~btn_inc_q.
  - Each history register updates every cycle; each edge is a one-cycle event.
- FSM states: RUN, SET_H, SET_M, SET_S; edit_sel encodes the state directly.
- Transitions on mode_evt: RUN->SET_H->SET_M->SET_S->RUN.
- Timeout: in any SET state, the timeout counter increments on tick_1hz. When the counter reaches TIMEOUT_S, the FSM goes to RUN on the next edge.
- Timeout counter clear: cleared on any mode_evt or inc_evt, and on entering RUN.
- RUN, on tick_1hz:
  - sec increments.
  - sec 59->0 carries to min; min 59->0 carries to hour.
  - H24=1: hour 23->0. H24=0: hour 12->1, and 11->12 is an ordinary increment.
  - All carries take effect in the same cycle: 23:59:59 becomes 00:00:00 in one clock.
  - inc_evt is ignored in RUN.
- SET_x, on inc_evt: the selected field increments with wrap and no carry.
  - sec: 59->0.
  - min: 59->0.
  - hour: 23->0 (H24=1) or 12->1 (H24=0).
- SET_S, on inc_evt: additionally, sec is cleared to 0 on the increment, i.e. sec is zeroed rather than incremented so the user can synchronise seconds. This is the one exception to the increment rule.
- Time freeze: time does not advance on tick_1hz in any SET state.
- Blink:
  - Toggles on each tick_1hz in SET states and forces to 1 on every inc_evt, so the edited field is visible immediately after a press.
  - Forced to 0 in RUN.
- Latency: all outputs are registered; a change appears one clock after the causing event.
- Simultaneous events:
  - mode_evt with inc_evt: the mode transition wins and inc_evt is dropped.
  - mode_evt with timeout expiry: go to RUN.
  - tick_1hz on the same cycle as a SET_S->RUN transition: the tick is not applied; counting resumes on the next tick.
  - tick_1hz with inc_evt in a SET state: the increment is applied, the timeout counter clears, and blink=1.
- Reset mid-operation: all state returns to the reset values immediately, regardless of the FSM state.
- Assertions:
  - Out-of-range field values are unreachable; the bench asserts they never occur.
  - tick_1hz is a single-cycle pulse by contract; the bench asserts it is never high two consecutive cycles.

Test Plan:
- Carry chain: reset, H24=1, preset via set mode to 23:59:58, return to RUN, 2 ticks -> 23:59:59 then 00:00:00 within the same clock as the second tick.
- Set cycle: 1 mode press -> edit_sel=1. 5 inc presses -> hour=5. 1 mode press, 30 inc presses -> min=30. 1 mode press, 1 inc press -> sec=0. 1 mode press -> edit_sel=0, and time advances by 1 on the next tick.
- Freeze/blink: in SET_M, apply 3 ticks -> sec unchanged, blink toggles 3 times. inc_evt -> blink=1 the next cycle. Return to RUN -> blink=0.
- Timeout: TIMEOUT_S=10, enter SET_H, apply 9 ticks -> still edit_sel=1. Press inc, apply 9 more ticks -> still edit_sel=1. One more tick -> edit_sel=0.
- Simultaneous: mode and inc rise on the same cycle in SET_H with hour=7 -> edit_sel=2, hour stays 7. Reset with btn_mode held through release -> no transition until btn_mode is released and pressed again.
- 12-hour mode: H24=0, reset -> hour=12. Set hour to 12, one inc -> hour=1. RUN from 12:59:59, one tick -> 01:00:00.
